// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button conditioner.
// Repeat FSM states are only used when BTN_AUTOREPEAT_EN is defined.
package button_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } btn_rpt_state_t;

   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// One button channel: synchroniser, debounce counter, edge pulses.
// Optional auto-repeat FSM enabled by defining BTN_AUTOREPEAT_EN.
module btn_channel
   import button_pkg::*;
#(
   parameter int SYNC_STAGES  = 2,
   parameter int STABLE_CNT   = 4,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_in,
   input  logic sample_tick,
   output logic btn_level,
   output logic btn_press,
   output logic btn_release,
   output logic btn_repeat
);

   localparam int CW = clog2_min1(STABLE_CNT);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [CW-1:0]          cnt;
   logic [CW-1:0]          cnt_nxt;
   logic                   level_nxt;
   logic                   rise;
   logic                   fall;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_q <= '0;
      else        sync_q <= {sync_q[SYNC_STAGES-2:0], btn_in};
   end

   assign s = sync_q[SYNC_STAGES-1];

   // a single agreeing sample discards the whole run
   always_comb begin
      level_nxt = btn_level;
      cnt_nxt   = cnt;
      if (sample_tick) begin
         if (s == btn_level) begin
            cnt_nxt = '0;
         end else if (cnt == CW'(STABLE_CNT - 1)) begin
            level_nxt = ~btn_level;
            cnt_nxt   = '0;
         end else begin
            cnt_nxt = cnt + CW'(1);
         end
      end
   end

   assign rise = level_nxt & ~btn_level;
   assign fall = ~level_nxt & btn_level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt         <= '0;
         btn_level   <= 1'b0;
         btn_press   <= 1'b0;
         btn_release <= 1'b0;
      end else begin
         cnt         <= cnt_nxt;
         btn_level   <= level_nxt;
         btn_press   <= rise;
         btn_release <= fall;
      end
   end

`ifdef BTN_AUTOREPEAT_EN
   localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int RW   = clog2_min1(RMAX + 1);

   btn_rpt_state_t st;
   btn_rpt_state_t st_nxt;
   logic [RW-1:0]  rcnt;
   logic [RW-1:0]  rcnt_nxt;
   logic           rpt_nxt;

   always_comb begin
      st_nxt   = st;
      rcnt_nxt = rcnt;
      rpt_nxt  = 1'b0;
      if (fall) begin
         st_nxt   = RPT_IDLE;
         rcnt_nxt = '0;
      end else begin
         unique case (st)
            RPT_IDLE: begin
               if (rise) begin
                  st_nxt   = RPT_DELAY;
                  rcnt_nxt = '0;
               end
            end
            RPT_DELAY: begin
               if (sample_tick) begin
                  if (rcnt == RW'(REPEAT_DELAY - 1)) begin
                     rpt_nxt  = 1'b1;
                     rcnt_nxt = '0;
                     st_nxt   = RPT_REPEAT;
                  end else begin
                     rcnt_nxt = rcnt + RW'(1);
                  end
               end
            end
            RPT_REPEAT: begin
               if (sample_tick) begin
                  if (rcnt == RW'(REPEAT_RATE - 1)) begin
                     rpt_nxt  = 1'b1;
                     rcnt_nxt = '0;
                  end else begin
                     rcnt_nxt = rcnt + RW'(1);
                  end
               end
            end
            default: begin
               st_nxt   = RPT_IDLE;
               rcnt_nxt = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st         <= RPT_IDLE;
         rcnt       <= '0;
         btn_repeat <= 1'b0;
      end else begin
         st         <= st_nxt;
         rcnt       <= rcnt_nxt;
         btn_repeat <= rpt_nxt;
      end
   end
`else
   assign btn_repeat = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Multi-channel button front end: shared sample prescaler plus CH channels.
// Define BTN_AUTOREPEAT_EN to build the per-channel auto-repeat FSM.
module button_conditioner
   import button_pkg::*;
#(
   parameter int CH           = 5,
   parameter int SAMPLE_DIV   = 100000,
   parameter int STABLE_CNT   = 4,
   parameter int SYNC_STAGES  = 2,
   parameter int REPEAT_DELAY = 50,
   parameter int REPEAT_RATE  = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CH-1:0] btn_in,
   output logic          sample_tick,
   output logic [CH-1:0] btn_level,
   output logic [CH-1:0] btn_press,
   output logic [CH-1:0] btn_release,
   output logic [CH-1:0] btn_repeat
);

   localparam int DW = clog2_min1(SAMPLE_DIV);

   logic [DW-1:0] div_cnt;
   logic          tick;

   assign tick        = (div_cnt == DW'(SAMPLE_DIV - 1));
   assign sample_tick = tick;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)    div_cnt <= '0;
      else if (tick) div_cnt <= '0;
      else           div_cnt <= div_cnt + DW'(1);
   end

   for (genvar i = 0; i < CH; i++) begin : g_ch
      btn_channel #(
         .SYNC_STAGES (SYNC_STAGES),
         .STABLE_CNT  (STABLE_CNT),
         .REPEAT_DELAY(REPEAT_DELAY),
         .REPEAT_RATE (REPEAT_RATE)
      ) u_ch (
         .clk        (clk),
         .rst_n      (rst_n),
         .btn_in     (btn_in[i]),
         .sample_tick(tick),
         .btn_level  (btn_level[i]),
         .btn_press  (btn_press[i]),
         .btn_release(btn_release[i]),
         .btn_repeat (btn_repeat[i])
      );
   end

endmodule
